// File: rtl/fb_rect_writer_pkg.sv
// rtl/fb_rect_writer_pkg.sv - display geometry and rectangle writer state encoding
package fb_rect_writer_pkg;

    // Frame geometry shared with the VGA timing controller
    localparam int FB_VIDEO_WIDTH           = 640;
    localparam int FB_VIDEO_HEIGHT          = 480;
    localparam int FB_PIXEL_ADDRESS_WIDTH   = 20;
    localparam int FB_PALETTE_ADDRESS_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        FILL    = 2'd2,
        FINISH  = 2'd3
    } fb_state_t;

endpackage

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - clipped solid-rectangle fill into the framebuffer
import fb_rect_writer_pkg::*;

module fb_rect_writer #(
    parameter int VIDEO_WIDTH           = FB_VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT          = FB_VIDEO_HEIGHT,
    parameter int PIXEL_ADDRESS_WIDTH   = FB_PIXEL_ADDRESS_WIDTH,
    parameter int PALETTE_ADDRESS_WIDTH = FB_PALETTE_ADDRESS_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [9:0]                       cmd_x,
    input  logic [8:0]                       cmd_y,
    input  logic [9:0]                       cmd_w,
    input  logic [8:0]                       cmd_h,
    input  logic [PALETTE_ADDRESS_WIDTH-1:0] cmd_color,
    input  logic                             cmd_sync,
    input  logic                             screenEnd,
    output logic                             wEn,
    output logic [PIXEL_ADDRESS_WIDTH-1:0]   addr,
    output logic [PALETTE_ADDRESS_WIDTH-1:0] dataIn,
    output logic                             busy,
    output logic                             done
);

    localparam logic [10:0] WIDTH_11  = 11'(VIDEO_WIDTH);
    localparam logic [10:0] HEIGHT_11 = 11'(VIDEO_HEIGHT);
    localparam logic [PIXEL_ADDRESS_WIDTH-1:0] ROW_STEP = PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH);

    fb_state_t state;

    logic [10:0] w_eff, h_eff;
    logic [10:0] col, row;
    logic [PIXEL_ADDRESS_WIDTH-1:0] row_base;

    logic [10:0] x_ext, y_ext, w_ext, h_ext;
    logic [10:0] w_room, h_room, w_clip, h_clip;
    logic        x_oob, y_oob, empty_cmd;
    logic [PIXEL_ADDRESS_WIDTH-1:0] start_addr;
    logic        last_col, last_row;

    // Clip the incoming command against the frame edge; the start address multiply only runs once per command
    always_comb begin
        x_ext      = {1'b0, cmd_x};
        y_ext      = {2'b00, cmd_y};
        w_ext      = {1'b0, cmd_w};
        h_ext      = {2'b00, cmd_h};
        x_oob      = (x_ext >= WIDTH_11);
        y_oob      = (y_ext >= HEIGHT_11);
        w_room     = x_oob ? 11'd0 : (WIDTH_11 - x_ext);
        h_room     = y_oob ? 11'd0 : (HEIGHT_11 - y_ext);
        w_clip     = (w_ext < w_room) ? w_ext : w_room;
        h_clip     = (h_ext < h_room) ? h_ext : h_room;
        empty_cmd  = x_oob || y_oob || (w_clip == 11'd0) || (h_clip == 11'd0);
        start_addr = PIXEL_ADDRESS_WIDTH'(cmd_x)
                   + PIXEL_ADDRESS_WIDTH'(cmd_y) * ROW_STEP;
        last_col   = (col == 11'(w_eff - 11'd1));
        last_row   = (row == 11'(h_eff - 11'd1));
    end

    // Command FSM with raster walker; every output is registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wEn       <= 1'b0;
            addr      <= '0;
            dataIn    <= '0;
            w_eff     <= '0;
            h_eff     <= '0;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        dataIn    <= cmd_color;
                        w_eff     <= w_clip;
                        h_eff     <= h_clip;
                        col       <= '0;
                        row       <= '0;
                        addr      <= start_addr;
                        row_base  <= start_addr;
                        if (empty_cmd) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (cmd_sync) begin
                            state <= WAIT_VB;
                        end else begin
                            state <= FILL;
                            wEn   <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WAIT_VB: begin
                    // Only pulses seen after the acceptance edge can reach this branch
                    if (screenEnd) begin
                        state <= FILL;
                        wEn   <= 1'b1;
                    end
                end
                FILL: begin
                    if (last_col) begin
                        if (last_row) begin
                            wEn   <= 1'b0;
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            col      <= '0;
                            row      <= 11'(row + 11'd1);
                            row_base <= row_base + ROW_STEP;
                            addr     <= row_base + ROW_STEP;
                        end
                    end else begin
                        col  <= 11'(col + 11'd1);
                        addr <= addr + PIXEL_ADDRESS_WIDTH'(1);
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fb_rect_writer.md
FB_RECT_WRITER -- requirements
Module: fb_rect_writer

Interface
REQ-001 SHALL have parameter VIDEO_WIDTH, default 640, frame width in pixels.
REQ-002 SHALL have parameter VIDEO_HEIGHT, default 480, frame height in pixels.
REQ-003 SHALL have parameter PIXEL_ADDRESS_WIDTH, default 20, framebuffer address width.
REQ-004 SHALL have parameter PALETTE_ADDRESS_WIDTH, default 9, palette-index (pixel data) width.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  rectangle command present.
REQ-008 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-009 SHALL have port cmd_x  input  10  left column; cmd_y  input  9  top row.
REQ-010 SHALL have port cmd_w  input  10  width; cmd_h  input  9  height.
REQ-011 SHALL have port cmd_color  input  PALETTE_ADDRESS_WIDTH  palette index to write.
REQ-012 SHALL have port cmd_sync  input  1  start only after the next screenEnd.
REQ-013 SHALL have port screenEnd  input  1  one-cycle frame-boundary pulse from the VGA timing generator.
REQ-014 SHALL have port wEn  output  1  framebuffer write strobe.
REQ-015 SHALL have port addr  output  PIXEL_ADDRESS_WIDTH  framebuffer write address.
REQ-016 SHALL have port dataIn  output  PALETTE_ADDRESS_WIDTH  framebuffer write data.
REQ-017 SHALL have ports busy  output  1  command in progress; done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, WAIT_VB, FILL, FINISH.
REQ-019 SHALL drive cmd_ready high only in IDLE; a command SHALL be accepted on the edge where cmd_valid and cmd_ready are both high, capturing all cmd_* fields.
REQ-020 SHALL clip at capture: effective width = min(cmd_w, VIDEO_WIDTH-cmd_x) and height = min(cmd_h, VIDEO_HEIGHT-cmd_y), using 11-bit arithmetic with no wrap.
REQ-021 SHALL treat cmd_x>=VIDEO_WIDTH, cmd_y>=VIDEO_HEIGHT, or a zero effective width/height as empty: go directly to FINISH and write nothing.
REQ-022 SHALL go IDLE->WAIT_VB when cmd_sync=1, else IDLE->FILL; WAIT_VB->FILL on the first screenEnd strictly after acceptance (a pulse in the acceptance cycle SHALL be ignored).
REQ-023 In FILL SHALL assert wEn every cycle, one pixel per cycle, row-major order, dataIn=captured color.
REQ-024 SHALL produce addr = x + VIDEO_WIDTH*y, generated incrementally (row base += VIDEO_WIDTH, no multiplier in the per-pixel path).
REQ-025 SHALL make the first write the cycle after acceptance (or after the qualifying screenEnd) and issue exactly w_eff*h_eff writes.
REQ-026 SHALL enter FINISH after the last write, pulse done for exactly one cycle there, then return to IDLE; cmd_ready SHALL be high the cycle after done.
REQ-027 SHALL hold busy high in WAIT_VB, FILL and FINISH, and low in IDLE.
REQ-028 SHALL ignore cmd_valid and cmd_* changes while not in IDLE.

Reset
REQ-029 On reset low, SHALL asynchronously force state=IDLE, wEn=0, addr=0, dataIn=0, busy=0, done=0, cmd_ready=0.
REQ-030 SHALL raise cmd_ready on the first clock edge after reset deasserts.
REQ-031 Reset mid-FILL SHALL abort immediately with no further writes and no done pulse.

Structure
REQ-032 SHALL take VIDEO_WIDTH, VIDEO_HEIGHT, and both address widths from the shared display package also used by the VGA controller.
REQ-033 SHALL define the state encoding as a typedef in that package.
REQ-034 SHALL be a single module with no sub-modules; column/row counters and address stepper SHALL be inline.

Verification
REQ-035 SHALL cover: cmd (x=10,y=2,w=3,h=2,color=5,sync=0) -> 6 writes, addr 1290,1291,1292,1930,1931,1932, dataIn=5, done one cycle after the last write.
REQ-036 SHALL cover: cmd (x=638,y=479,w=5,h=4) -> exactly 2 writes at addr 307198,307199.
REQ-037 SHALL cover: cmd w=0, or x=700 -> no wEn, done pulse, cmd_ready high next cycle.
REQ-038 SHALL cover: sync=1 with screenEnd in the acceptance cycle and again 50 cycles later -> first write the cycle after the second pulse.
REQ-039 SHALL cover: reset low after the 3rd write of a 100-pixel command -> wEn low immediately, no done, cmd_ready high one edge after release.
REQ-040 SHALL cover: cmd_valid held high through two back-to-back commands -> second accepted only in IDLE after done, with no overlap of writes.
